uart_rx_packet_ctrl: RTL

Frame controller that sits directly behind the UART receiver and sequences its byte stream into checked packets. It consumes the receiver's one-cycle byte flag and byte value, then parses frames of the form SOF, LEN, payload, checksum. Payload is buffered internally and released on a valid/ready stream only when the checksum matches. Malformed, stalled or overrun frames are discarded with an error pulse.

---
 rtl/uart_rx_packet_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_packet_ctrl.sv
// Packet framer behind a UART receiver: parses SOF/LEN/payload/checksum frames,
// buffers the payload and releases it on a valid/ready stream once the checksum matches.
module uart_rx_packet_ctrl #(
   parameter logic [7:0]  SOF_BYTE     = 8'hA5,
   parameter int unsigned MAX_LEN      = 16,
   parameter int unsigned TIMEOUT_CLKS = 52080
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_flag,
   input  logic [7:0] rx_byte,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic       m_last,
   input  logic       m_ready,
   output logic [7:0] pkt_len,
   output logic       pkt_ok,
   output logic       err_chk,
   output logic       err_len,
   output logic       err_timeout,
   output logic       err_overrun,
   output logic       busy
);

   localparam int unsigned IW = $clog2(MAX_LEN + 1);
   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CLKS);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CHK     = 3'd3,
      S_DRAIN   = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   len_q, len_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   rd_q, rd_d;
   logic [7:0]      sum_q, sum_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [7:0]      mem_q [MAX_LEN];
   logic            mem_we;

   logic            m_valid_q, m_valid_d;
   logic [7:0]      m_data_q, m_data_d;
   logic            m_last_q, m_last_d;
   logic [7:0]      pkt_len_q, pkt_len_d;
   logic            pkt_ok_q, pkt_ok_d;
   logic            err_chk_q, err_chk_d;
   logic            err_len_q, err_len_d;
   logic            err_timeout_q, err_timeout_d;
   logic            err_overrun_q, err_overrun_d;
   logic            busy_q, busy_d;

   logic            ok_ev, chk_ev, len_ev, tmo_ev, ovr_ev;
   logic            tmo_hit;
   logic            counting;
   logic [IW-1:0]   len_m1;

   assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CLKS - 1));
   assign len_m1   = len_q - IW'(1);
   assign counting = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      rd_d    = rd_q;
      sum_d   = sum_q;
      mem_we  = 1'b0;
      ok_ev   = 1'b0;
      chk_ev  = 1'b0;
      len_ev  = 1'b0;
      tmo_ev  = 1'b0;
      ovr_ev  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rx_flag && (rx_byte == SOF_BYTE)) begin
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (rx_flag) begin
               if ((rx_byte != 8'h00) && (rx_byte <= 8'(MAX_LEN))) begin
                  len_d   = IW'(rx_byte);
                  sum_d   = rx_byte;
                  idx_d   = '0;
                  state_d = S_PAYLOAD;
               end else begin
                  len_ev  = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (tmo_hit) begin
               tmo_ev  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_PAYLOAD: begin
            if (rx_flag) begin
               mem_we = 1'b1;
               sum_d  = sum_q + rx_byte;
               idx_d  = idx_q + IW'(1);
               if (idx_q == len_m1) begin
                  state_d = S_CHK;
               end
            end else if (tmo_hit) begin
               tmo_ev  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_CHK: begin
            if (rx_flag) begin
               if (rx_byte == sum_q) begin
                  ok_ev   = 1'b1;
                  rd_d    = '0;
                  state_d = S_DRAIN;
               end else begin
                  chk_ev  = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (tmo_hit) begin
               tmo_ev  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            ovr_ev = rx_flag;
            if (m_valid_q && m_ready) begin
               if (rd_q == len_m1) begin
                  state_d = S_IDLE;
               end else begin
                  rd_d = rd_q + IW'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Inter-byte timer: runs only while idle-waiting inside a frame
   always_comb begin
      tmo_d = '0;
      if (counting && !rx_flag && (state_d == state_q)) begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   // Registered output values
   always_comb begin
      m_valid_d     = (state_d == S_DRAIN);
      m_data_d      = 8'h00;
      m_last_d      = 1'b0;
      pkt_len_d     = pkt_len_q;
      pkt_ok_d      = ok_ev;
      err_chk_d     = chk_ev;
      err_len_d     = len_ev;
      err_timeout_d = tmo_ev;
      err_overrun_d = ovr_ev;
      busy_d        = (state_d != S_IDLE);
      if (ok_ev) begin
         pkt_len_d = 8'(len_q);
      end
      if (state_d == S_DRAIN) begin
         m_data_d = mem_q[rd_d[AW-1:0]];
         m_last_d = (rd_d == len_m1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q         <= '0;
         idx_q         <= '0;
         rd_q          <= '0;
         sum_q         <= '0;
         tmo_q         <= '0;
         m_valid_q     <= 1'b0;
         m_data_q      <= 8'h00;
         m_last_q      <= 1'b0;
         pkt_len_q     <= 8'h00;
         pkt_ok_q      <= 1'b0;
         err_chk_q     <= 1'b0;
         err_len_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         err_overrun_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         len_q         <= len_d;
         idx_q         <= idx_d;
         rd_q          <= rd_d;
         sum_q         <= sum_d;
         tmo_q         <= tmo_d;
         m_valid_q     <= m_valid_d;
         m_data_q      <= m_data_d;
         m_last_q      <= m_last_d;
         pkt_len_q     <= pkt_len_d;
         pkt_ok_q      <= pkt_ok_d;
         err_chk_q     <= err_chk_d;
         err_len_q     <= err_len_d;
         err_timeout_q <= err_timeout_d;
         err_overrun_q <= err_overrun_d;
         busy_q        <= busy_d;
      end
   end

   // Payload buffer; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[idx_q[AW-1:0]] <= rx_byte;
      end
   end

   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign m_last      = m_last_q;
   assign pkt_len     = pkt_len_q;
   assign pkt_ok      = pkt_ok_q;
   assign err_chk     = err_chk_q;
   assign err_len     = err_len_q;
   assign err_timeout = err_timeout_q;
   assign err_overrun = err_overrun_q;
   assign busy        = busy_q;

endmodule
